conv_output_writer: RTL and testbench
=====================================

Name: conv_output_writer

Overview:
- Consumer at the far end of the line-buffer window pipeline.
- Takes the sparse stream of valid convolution results, one pulse per legal window position.
- Packs the results densely into an output feature-map memory in raster order: linear address = row*OUT_SIZE + col.
- Tracks frame progress, flags protocol errors and signals frame completion to the layer sequencer.

Parameters:
- FILTER_SIZE, 3: kernel edge length. Must match the upstream line buffer.
- IMAGE_SIZE, 28: input feature-map edge length.
- STRIDE, 1: window stride. Must match upstream.
- DATA_WIDTH, 16: signed result width.
- Derived localparam OUT_SIZE = (IMAGE_SIZE-FILTER_SIZE)/STRIDE + 1.
- Derived localparam OUT_PIXELS = OUT_SIZE*OUT_SIZE.
- Derived localparam ADDR_W = `LOG2(OUT_PIXELS).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle pulse that arms collection of one frame.
- in_valid, input, 1: window result valid. Driven from the upstream valid, which is already gated by clk_en.
- in_data, input, DATA_WIDTH: signed window result.
- wr_en, output, 1: output memory write strobe.
- wr_addr, output, ADDR_W: output memory write address.
- wr_data, output, DATA_WIDTH: output memory write data.
- busy, output, 1: high while collecting.
- frame_done, output, 1: single-cycle pulse on the final write of a frame.
- drop_err, output, 1: sticky flag; a result arrived while not collecting.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, drop_err=0.
  - Column/row/address counters go to 0.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE -> COLLECT on start. Counters are cleared. drop_err is cleared on the same edge.
  - COLLECT -> DONE on the accepted result whose address is OUT_PIXELS-1.
  - DONE -> IDLE unconditionally on the next cycle.
  - busy = (state==COLLECT).
- Acceptance:
  - in_valid is accepted in COLLECT.
  - in_valid is also accepted in IDLE in the same cycle as start; it becomes address 0.
  - Any other in_valid (IDLE without start, or DONE) is dropped: no write, drop_err set and held until the next start or reset.
- Latency: exactly 1 cycle, fully registered.
  - Result accepted at edge N gives wr_en=1 in cycle N+1, with wr_addr = current linear count and wr_data = processed in_data.
  - wr_en is low in every cycle with no accepted result. wr_addr/wr_data hold their last values when idle.
- Counters:
  - col runs 0..OUT_SIZE-1, row runs 0..OUT_SIZE-1, lin runs 0..OUT_PIXELS-1.
  - All three increment only on an accepted result.
  - col wraps to 0 and row increments when col==OUT_SIZE-1.
  - lin is an incrementing counter; no multiplier.
  - After the final result, all counters wrap to 0.
- frame_done: asserted in the same cycle as the wr_en for address OUT_PIXELS-1. Never asserted otherwise.
- Back-to-back results every cycle must be sustained with no loss (STRIDE=1 case).
- start while in COLLECT or DONE is ignored. There is no restart mid-frame; the frame must complete or rst_n must be asserted.
- Reset mid-frame: all state is abandoned immediately. Any pending wr_en is deasserted asynchronously.
- Width rules:
  - wr_data is the same width as in_data; no truncation in the base configuration.
  - The address counter is sized ADDR_W. It never exceeds OUT_PIXELS-1.

Optional Feature:
- Macro: CONV_OUT_RELU_EN.
- Defined: wr_data = (in_data[DATA_WIDTH-1] ? 0 : in_data). Signed negatives are clamped to zero in the registered stage. Latency is unchanged.
- Undefined: wr_data = in_data, unchanged. The clamp logic is not compiled.

Decomposition:
- Shared package/header holds:
  - the `LOG2 macro (existing);
  - the OUT_SIZE derivation expressed as a reusable macro, so the line buffer and this block compute it identically;
  - the FSM state encodings (IDLE=2'd0, COLLECT=2'd1, DONE=2'd2).
- One natural sub-module: out_pos_counter. It holds the col/row/lin counters with increment-on-enable, wrap and last-position flag. It is reusable by future pooling writers.

Test Plan:
- Frame, OUT_SIZE=4 (IMAGE_SIZE=6, FILTER_SIZE=3, STRIDE=1): start, then 16 back-to-back in_valid with data 1..16.
  - -> 16 writes at addresses 0..15, each one cycle after its input.
  - -> frame_done only with the address-15 write.
  - -> busy falls afterwards.
- IMAGE_SIZE=7, FILTER_SIZE=3, STRIDE=2 (OUT_SIZE=3): 9 results spaced irregularly with 0–5 idle cycles.
  - -> addresses 0..8 with no gaps.
  - -> wr_en low on idle cycles.
  - -> frame_done with address 8.
- in_valid=1 with no start, data 0x00AA -> no wr_en; drop_err=1 and stays set; the next start clears it.
- start and in_valid together in IDLE with data 0x0005 -> write address 0, data 0x0005. A second frame run immediately after DONE restarts at address 0.
- rst_n pulsed low after 7 of 16 results -> outputs are 0 immediately. A new start gives a first write at address 0.
- CONV_OUT_RELU_EN defined, inputs 0xFFFE, 0x0003 -> wr_data 0x0000, 0x0003. With the macro undefined -> 0xFFFE, 0x0003.

Source files
------------

// File: rtl/conv_output_writer_pkg.sv
// Shared definitions for the convolution output writer and its line-buffer peers.
// Holds the width/size macros and the writer FSM state encoding.
// Optional feature macro used by the writer: CONV_OUT_RELU_EN (clamp negatives to zero).

`ifndef LOG2
`define LOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

// Output edge length of a valid (unpadded) convolution; the line buffer uses the same expression.
`ifndef CONV_OUT_SIZE
`define CONV_OUT_SIZE(img, flt, strd) ((((img) - (flt)) / (strd)) + 1)
`endif

package conv_output_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } wr_state_e;

endpackage

// File: rtl/conv_output_writer_pos_counter.sv
// out_pos_counter: raster position tracker (col/row/linear) for dense output-map writers.
// Outputs describe the position the next accepted item will take; clr restarts at 0 in the same cycle.
// Counters advance only on en and wrap to 0 after the last position of the map.

module out_pos_counter #(
  parameter int OUT_SIZE = 26,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] lin,
  output logic              last
);

  localparam int OUT_PIXELS = OUT_SIZE * OUT_SIZE;
  localparam int CW         = `LOG2(OUT_SIZE);
  localparam logic [CW-1:0]     COORD_MAX = CW'(OUT_SIZE - 1);
  localparam logic [ADDR_W-1:0] LIN_MAX   = ADDR_W'(OUT_PIXELS - 1);

  logic [CW-1:0]     col_q, col_d, col_cur;
  logic [CW-1:0]     row_q, row_d, row_cur;
  logic [ADDR_W-1:0] lin_q, lin_d, lin_cur;

  // Current position: a clear overrides the stored counters so a start can take position 0 at once.
  always_comb begin
    col_cur = clr ? '0 : col_q;
    row_cur = clr ? '0 : row_q;
    lin_cur = clr ? '0 : lin_q;
  end

  assign lin  = lin_cur;
  assign last = (col_cur == COORD_MAX) && (row_cur == COORD_MAX);

  // Advance one raster position per enable; col wraps into row, everything wraps after the last pixel.
  always_comb begin
    col_d = col_cur;
    row_d = row_cur;
    lin_d = lin_cur;
    if (en) begin
      if (col_cur == COORD_MAX) begin
        col_d = '0;
        row_d = (row_cur == COORD_MAX) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
      end
      lin_d = (lin_cur == LIN_MAX) ? '0 : lin_cur + 1'b1;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      lin_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      lin_q <= lin_d;
    end
  end

endmodule

// File: rtl/conv_output_writer.sv
// conv_output_writer: packs sparse window results densely into the output map in raster order.
// Latency 1 cycle (fully registered write port); sustains one result per cycle, no backpressure.
// Results outside a frame are dropped and flagged on drop_err. CONV_OUT_RELU_EN clamps negatives.

module conv_output_writer
  import conv_output_writer_pkg::*;
#(
  parameter int FILTER_SIZE = 3,
  parameter int IMAGE_SIZE  = 28,
  parameter int STRIDE      = 1,
  parameter int DATA_WIDTH  = 16,
  localparam int OUT_SIZE   = `CONV_OUT_SIZE(IMAGE_SIZE, FILTER_SIZE, STRIDE),
  localparam int OUT_PIXELS = OUT_SIZE * OUT_SIZE,
  localparam int ADDR_W     = `LOG2(OUT_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  drop_err
);

  wr_state_e             state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  drop_err_q, drop_err_d;

  logic                  arm;
  logic                  accept;
  logic                  drop;
  logic [ADDR_W-1:0]     pos_lin;
  logic                  pos_last;
  logic [DATA_WIDTH-1:0] proc_data;

  // A start in IDLE arms the frame and may carry the first result in the same cycle.
  assign arm    = (state_q == ST_IDLE) && start;
  assign accept = in_valid && ((state_q == ST_COLLECT) || arm);
  assign drop   = in_valid && !accept;

  out_pos_counter #(
    .OUT_SIZE (OUT_SIZE),
    .ADDR_W   (ADDR_W)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (arm),
    .en    (accept),
    .lin   (pos_lin),
    .last  (pos_last)
  );

`ifdef CONV_OUT_RELU_EN
  // Negative results are clamped to zero before the write register.
  assign proc_data = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign proc_data = in_data;
`endif

  // Frame FSM plus next values of the registered write port and status flags.
  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    drop_err_d   = drop_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_COLLECT;
          drop_err_d = 1'b0;
        end
      end
      ST_COLLECT: state_d = ST_COLLECT;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (accept) begin
      wr_en_d      = 1'b1;
      wr_addr_d    = pos_lin;
      wr_data_d    = proc_data;
      frame_done_d = pos_last;
      if (pos_last) begin
        state_d = ST_DONE;
      end
    end

    if (drop) begin
      drop_err_d = 1'b1;
    end
  end

  // State and output registers; reset abandons any frame in progress immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign drop_err   = drop_err_q;
  assign busy       = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_conv_output_writer.sv
// Bench for conv_output_writer: two instances (4x4 output, stride 1; 3x3 output, stride 2).
// A frame-level model predicts every output each cycle; directed steps add literal expectations.
// Macro CONV_OUT_RELU_EN selects the expected clamp behaviour.

module tb_conv_output_writer;

  localparam int DW = 16;
  localparam int AW = 4;              // 16 and 9 output pixels both need 4 address bits
  localparam int OPIX [2] = '{16, 9};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start    [2];
  logic          in_valid [2];
  logic [DW-1:0] in_data  [2];
  logic          wr_en    [2];
  logic [AW-1:0] wr_addr  [2];
  logic [DW-1:0] wr_data  [2];
  logic          busy     [2];
  logic          frame_done [2];
  logic          drop_err [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_output_writer #(.FILTER_SIZE(3), .IMAGE_SIZE(6), .STRIDE(1), .DATA_WIDTH(DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .busy(busy[0]),
    .frame_done(frame_done[0]), .drop_err(drop_err[0]));

  conv_output_writer #(.FILTER_SIZE(3), .IMAGE_SIZE(7), .STRIDE(2), .DATA_WIDTH(DW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .busy(busy[1]),
    .frame_done(frame_done[1]), .drop_err(drop_err[1]));

  // ---------------- frame-level model ----------------
  typedef struct {
    bit            coll;   // a frame is being collected
    bit            cool;   // the cycle right after a finished frame
    int            cnt;    // results written so far in this frame
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            done;
    bit            drop;
  } mstate_t;

  mstate_t m [2];

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
`ifdef CONV_OUT_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  function automatic mstate_t zero_state();
    mstate_t z;
    z.coll = 0; z.cool = 0; z.cnt = 0; z.wr = 0;
    z.addr = '0; z.data = '0; z.done = 0; z.drop = 0;
    return z;
  endfunction

  function automatic mstate_t step(input mstate_t s, input int opix, input bit st,
                                   input bit v, input logic [DW-1:0] d);
    mstate_t n;
    n = s;
    n.wr = 0;
    n.done = 0;
    if (st && !s.coll && !s.cool) begin
      n.coll = 1; n.cnt = 0; n.drop = 0;
    end
    n.cool = 0;
    if (v) begin
      if (n.coll) begin
        n.wr   = 1;
        n.addr = AW'(n.cnt);
        n.data = relu(d);
        if (n.cnt == opix - 1) begin
          n.done = 1; n.coll = 0; n.cnt = 0; n.cool = 1;
        end else begin
          n.cnt = n.cnt + 1;
        end
      end else begin
        n.drop = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) m[i] <= zero_state();
    end else begin
      for (int i = 0; i < 2; i++) m[i] <= step(m[i], OPIX[i], start[i], in_valid[i], in_data[i]);
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got 0x%0h, expected 0x%0h", nm, i, $time, act, exp);
    end
  endtask

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("wr_en",      i, 32'(wr_en[i]),      32'(m[i].wr));
      chk("wr_addr",    i, 32'(wr_addr[i]),    32'(m[i].addr));
      chk("wr_data",    i, 32'(wr_data[i]),    32'(m[i].data));
      chk("busy",       i, 32'(busy[i]),       32'(m[i].coll));
      chk("frame_done", i, 32'(frame_done[i]), 32'(m[i].done));
      chk("drop_err",   i, 32'(drop_err[i]),   32'(m[i].drop));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int i, input bit st, input bit v, input logic [DW-1:0] d);
    start[i] = st; in_valid[i] = v; in_data[i] = d;
    @(posedge clk); #1;
    start[i] = 1'b0; in_valid[i] = 1'b0;
  endtask

  task automatic chk_zero(input string nm, input int i);
    chk({nm, "_wr_en"},   i, 32'(wr_en[i]),   0);
    chk({nm, "_wr_addr"}, i, 32'(wr_addr[i]), 0);
    chk({nm, "_wr_data"}, i, 32'(wr_data[i]), 0);
    chk({nm, "_busy"},    i, 32'(busy[i]),    0);
    chk({nm, "_done"},    i, 32'(frame_done[i]), 0);
    chk({nm, "_drop"},    i, 32'(drop_err[i]), 0);
  endtask

  int gaps [9] = '{0, 3, 1, 5, 0, 2, 4, 1, 0};
  logic [DW-1:0] neg_exp;

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0;
    end
`ifdef CONV_OUT_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hFFFE;
`endif
    #2;
    chk_zero("reset", 0);
    chk_zero("reset", 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Result with no frame armed is dropped and the flag sticks.
    cyc(0, 0, 1, 16'h00AA);
    chk("drop_wr_en", 0, 32'(wr_en[0]), 0);
    chk("drop_flag", 0, 32'(drop_err[0]), 1);
    cyc(0, 0, 0, '0);
    chk("drop_sticky", 0, 32'(drop_err[0]), 1);

    // Frame 1: start, then 16 back-to-back results 1..16.
    cyc(0, 1, 0, '0);
    chk("start_clears_drop", 0, 32'(drop_err[0]), 0);
    chk("start_busy", 0, 32'(busy[0]), 1);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 0, 1, DW'(k));
      chk("f1_wr_en", 0, 32'(wr_en[0]), 1);
      chk("f1_addr", 0, 32'(wr_addr[0]), 32'(k - 1));
      chk("f1_done", 0, 32'(frame_done[0]), (k == 16) ? 1 : 0);
    end
    chk("f1_last_data", 0, 32'(wr_data[0]), 16);
    chk("f1_busy_fell", 0, 32'(busy[0]), 0);
    cyc(0, 0, 0, '0);
    chk("f1_idle_wr_en", 0, 32'(wr_en[0]), 0);
    chk("f1_hold_addr", 0, 32'(wr_addr[0]), 15);

    // Frame 2: start and first result together in IDLE.
    cyc(0, 1, 1, 16'h0005);
    chk("f2_addr0", 0, 32'(wr_addr[0]), 0);
    chk("f2_data0", 0, 32'(wr_data[0]), 5);
    for (int k = 2; k <= 16; k++) cyc(0, 0, 1, DW'(k + 100));
    chk("f2_done", 0, 32'(frame_done[0]), 1);
    chk("f2_addr15", 0, 32'(wr_addr[0]), 15);
    // DONE cycle: start is ignored and the result is dropped.
    cyc(0, 1, 1, 16'h0033);
    chk("done_drop_wr_en", 0, 32'(wr_en[0]), 0);
    chk("done_drop_flag", 0, 32'(drop_err[0]), 1);

    // Frame 3 immediately after DONE, carrying the clamp vectors.
    cyc(0, 1, 1, 16'hFFFE);
    chk("f3_addr0", 0, 32'(wr_addr[0]), 0);
    chk("f3_neg_data", 0, 32'(wr_data[0]), 32'(neg_exp));
    chk("f3_drop_cleared", 0, 32'(drop_err[0]), 0);
    cyc(0, 0, 1, 16'h0003);
    chk("f3_addr1", 0, 32'(wr_addr[0]), 1);
    chk("f3_pos_data", 0, 32'(wr_data[0]), 3);
    for (int k = 3; k <= 7; k++) cyc(0, 0, 1, DW'(k));
    chk("f3_wr_en_pre_rst", 0, 32'(wr_en[0]), 1);
    chk("f3_addr6", 0, 32'(wr_addr[0]), 6);

    // Asynchronous reset mid-frame clears outputs before any clock edge.
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst", 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(0, 1, 0, '0);
    cyc(0, 0, 1, 16'h0042);
    chk("after_rst_addr", 0, 32'(wr_addr[0]), 0);
    chk("after_rst_data", 0, 32'(wr_data[0]), 32'h42);

    // Stride-2 instance: 9 results with irregular idle gaps.
    cyc(1, 1, 0, '0);
    for (int r = 0; r < 9; r++) begin
      for (int g = 0; g < gaps[r]; g++) begin
        cyc(1, 0, 0, '0);
        chk("s2_gap_wr_en", 1, 32'(wr_en[1]), 0);
      end
      cyc(1, 0, 1, DW'(r * 7 + 1));
      chk("s2_addr", 1, 32'(wr_addr[1]), 32'(r));
      chk("s2_done", 1, 32'(frame_done[1]), (r == 8) ? 1 : 0);
    end
    chk("s2_last_data", 1, 32'(wr_data[1]), 57);
    cyc(1, 0, 0, '0);
    chk("s2_busy_end", 1, 32'(busy[1]), 0);
    chk("s2_done_pulse", 1, 32'(frame_done[1]), 0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
